ncc_match_engine: RTL and testbench

- Parametrised successor to the 16x16 log2-domain NCC correlator.
- Computes the exact integer dot product between a stored descriptor patch and a stream of candidate windows.
- Emits one score per window and tracks the best score and its window index across a search.
- Sits between the descriptor/window fetch logic and the tracking controller.

---
 rtl/ncc_pkg.sv | 45 ++++
 rtl/ncc_row_dot.sv | 39 +++
 rtl/ncc_match_engine.sv | 168 ++++++++++++++++
 tb/tb_ncc_match_engine.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ncc_pkg
// Purpose  : Shared types and sizing helpers for the NCC match engine.
//            Holds the controller state type, default derived sizes and the
//            parameter-legality function evaluated at elaboration time.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package ncc_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no descriptor stored
        LOAD  = 2'd1,   // descriptor beats arriving
        READY = 2'd2    // descriptor complete, windows may stream
    } ncc_state_t;

    function automatic int num_pix(input int dim);
        return dim * dim;
    endfunction

    function automatic int num_beats(input int dim, input int lanes);
        return (dim * dim) / lanes;
    endfunction

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int dim, input int pix_w,
                                     input int lanes, input int acc_w,
                                     input int idx_w);
        return (dim >= 2) && (pix_w >= 1) && (lanes >= 1) && (idx_w >= 1) &&
               (((dim * dim) % lanes) == 0) &&
               (acc_w >= 2 * pix_w + 2 * $clog2(dim));
    endfunction

    // Derived sizes for the default 16x16, 4-lane configuration.
    localparam int NUM_PIX    = num_pix(16);
    localparam int NUM_BEATS  = num_beats(16, 4);
    localparam int ROW_CNT_W  = cnt_w(16);
    localparam int LOAD_CNT_W = cnt_w(NUM_BEATS);

endpackage : ncc_pkg
`default_nettype wire

// File: rtl/ncc_row_dot.sv
`default_nettype none
// ============================================================================
// Module   : ncc_row_dot
// Purpose  : Combinational unsigned dot product of one descriptor row with
//            one window row (PATCH_DIM multipliers and a summing tree).
// Ports    : desc_row - PATCH_DIM pixels, column 0 in LSBs
//            win_row  - PATCH_DIM pixels, column 0 in LSBs
//            rowsum   - sum of per-column products, zero-extended to OUT_W
// Revision : 1.0 - initial release
// ============================================================================
module ncc_row_dot
    import ncc_pkg::*;
#(
    parameter int PATCH_DIM = 16,
    parameter int PIX_W     = 8,
    parameter int OUT_W     = 32
) (
    input  logic [PATCH_DIM*PIX_W-1:0] desc_row,
    input  logic [PATCH_DIM*PIX_W-1:0] win_row,
    output logic [OUT_W-1:0]           rowsum
);

    logic [2*PIX_W-1:0] prod [PATCH_DIM];

    for (genvar c = 0; c < PATCH_DIM; c++) begin : g_lane
        // Operands widened first so the product keeps its full 2*PIX_W bits.
        assign prod[c] = {{PIX_W{1'b0}}, desc_row[c*PIX_W +: PIX_W]} *
                         {{PIX_W{1'b0}}, win_row[c*PIX_W +: PIX_W]};
    end

    always_comb begin
        rowsum = '0;
        for (int c = 0; c < PATCH_DIM; c++) begin
            rowsum = rowsum + {{(OUT_W-2*PIX_W){1'b0}}, prod[c]};
        end
    end

endmodule : ncc_row_dot
`default_nettype wire

// File: rtl/ncc_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : ncc_match_engine
// Purpose  : Stores a PATCH_DIM x PATCH_DIM descriptor and correlates it
//            against a stream of candidate windows, one row per cycle.
//            Emits a score per window and the best score/index per search.
// Ports    : clk, rst (async, active low), clear (sync abandon)
//            desc_valid/desc_ready/desc_data  - descriptor load beats
//            desc_loaded                      - full descriptor present
//            win_valid/win_ready/win_row      - window rows, win_last on the
//                                               final row of a search
//            score_valid/score/score_idx      - per-window result pulse
//            best_valid/best_score/best_idx   - per-search result pulse
// Revision : 1.0 - initial parametrised release
// ============================================================================
module ncc_match_engine
    import ncc_pkg::*;
#(
    parameter int PATCH_DIM = 16,
    parameter int PIX_W     = 8,
    parameter int LANES     = 4,
    parameter int ACC_W     = 32,
    parameter int IDX_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic [LANES*PIX_W-1:0]     desc_data,
    output logic                       desc_loaded,
    input  logic                       win_valid,
    output logic                       win_ready,
    input  logic [PATCH_DIM*PIX_W-1:0] win_row,
    input  logic                       win_last,
    output logic                       score_valid,
    output logic [ACC_W-1:0]           score,
    output logic [IDX_W-1:0]           score_idx,
    output logic                       best_valid,
    output logic [ACC_W-1:0]           best_score,
    output logic [IDX_W-1:0]           best_idx
);

    localparam int PIX_TOTAL = num_pix(PATCH_DIM);
    localparam int BEATS     = num_beats(PATCH_DIM, LANES);
    localparam int RC_W      = cnt_w(PATCH_DIM);
    localparam int LC_W      = cnt_w(BEATS);
    localparam int ROW_BITS  = PATCH_DIM * PIX_W;
    localparam int BEAT_BITS = LANES * PIX_W;

    if (!params_ok(PATCH_DIM, PIX_W, LANES, ACC_W, IDX_W)) begin : g_param_check
        $error("ncc_match_engine: illegal parameter combination");
    end

    ncc_state_t                  state;
    logic [PIX_TOTAL*PIX_W-1:0]  desc_mem;
    logic [LC_W-1:0]             load_cnt;
    logic [RC_W-1:0]             row_cnt;
    logic [ACC_W-1:0]            acc;
    logic [IDX_W-1:0]            win_idx;
    logic                        first_win;

    logic [ROW_BITS-1:0]         desc_row;
    logic [ACC_W-1:0]            rowsum;
    logic [ACC_W-1:0]            win_total;
    logic                        row_zero;
    logic                        row_final;
    logic                        beat_final;
    logic                        desc_take;
    logic                        win_take;

    assign row_zero   = (row_cnt == '0);
    assign row_final  = (row_cnt == RC_W'(PATCH_DIM-1));
    assign beat_final = (load_cnt == LC_W'(BEATS-1));

    // A descriptor may only be replaced between windows; when one is offered
    // at a window boundary it takes priority over the next window row.
    assign desc_ready = !clear && ((state != READY) || row_zero);
    assign win_ready  = !clear && (state == READY) && !(desc_valid && row_zero);
    assign desc_take  = desc_valid && desc_ready;
    assign win_take   = win_valid && win_ready;

    assign desc_row  = desc_mem[int'(row_cnt)*ROW_BITS +: ROW_BITS];
    // Row 0 starts a fresh window, so the stale accumulator is ignored.
    assign win_total = (row_zero ? '0 : acc) + rowsum;

    ncc_row_dot #(
        .PATCH_DIM (PATCH_DIM),
        .PIX_W     (PIX_W),
        .OUT_W     (ACC_W)
    ) u_row_dot (
        .desc_row  (desc_row),
        .win_row   (win_row),
        .rowsum    (rowsum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            desc_mem    <= '0;
            load_cnt    <= '0;
            row_cnt     <= '0;
            acc         <= '0;
            win_idx     <= '0;
            first_win   <= 1'b1;
            desc_loaded <= 1'b0;
            score_valid <= 1'b0;
            score       <= '0;
            score_idx   <= '0;
            best_valid  <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
        end else begin
            score_valid <= 1'b0;
            best_valid  <= 1'b0;
            if (clear) begin
                row_cnt   <= '0;
                win_idx   <= '0;
                first_win <= 1'b1;
                if (state == LOAD) begin
                    load_cnt <= '0;
                    state    <= EMPTY;
                end
            end else begin
                if (desc_take) begin
                    desc_mem[int'(load_cnt)*BEAT_BITS +: BEAT_BITS] <= desc_data;
                    if (beat_final) begin
                        load_cnt    <= '0;
                        state       <= READY;
                        desc_loaded <= 1'b1;
                    end else begin
                        load_cnt    <= load_cnt + 1'b1;
                        state       <= LOAD;
                        desc_loaded <= 1'b0;
                    end
                end
                if (win_take) begin
                    acc <= win_total;
                    if (row_final) begin
                        row_cnt     <= '0;
                        score_valid <= 1'b1;
                        score       <= win_total;
                        score_idx   <= win_idx;
                        // Strict compare: a tie keeps the earlier index.
                        if (first_win || (win_total > best_score)) begin
                            best_score <= win_total;
                            best_idx   <= win_idx;
                        end
                        if (win_last) begin
                            best_valid <= 1'b1;
                            first_win  <= 1'b1;
                            win_idx    <= '0;
                        end else begin
                            first_win <= 1'b0;
                            if (win_idx != '1) begin
                                win_idx <= win_idx + 1'b1;
                            end
                        end
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule : ncc_match_engine
`default_nettype wire

// File: tb/tb_ncc_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncc_match_engine
// Purpose  : Self-checking bench for ncc_match_engine (16x16, 8-bit, 4 lanes).
//            Directed table, hand-written corner sequences and randomized
//            windows compared against a whole-window behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ncc_match_engine;

    localparam int PD  = 16;
    localparam int PW  = 8;
    localparam int LN  = 4;
    localparam int AW  = 32;
    localparam int IW  = 16;
    localparam int NB  = PD * PD / LN;
    localparam int BUDGET = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              desc_valid;
    logic              desc_ready;
    logic [LN*PW-1:0]  desc_data;
    logic              desc_loaded;
    logic              win_valid;
    logic              win_ready;
    logic [PD*PW-1:0]  win_row;
    logic              win_last;
    logic              score_valid;
    logic [AW-1:0]     score;
    logic [IW-1:0]     score_idx;
    logic              best_valid;
    logic [AW-1:0]     best_score;
    logic [IW-1:0]     best_idx;

    ncc_match_engine #(
        .PATCH_DIM (PD), .PIX_W (PW), .LANES (LN), .ACC_W (AW), .IDX_W (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_data   (desc_data),
        .desc_loaded (desc_loaded),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_last    (win_last),
        .score_valid (score_valid),
        .score       (score),
        .score_idx   (score_idx),
        .best_valid  (best_valid),
        .best_score  (best_score),
        .best_idx    (best_idx)
    );

    always #5 clk = ~clk;

    int cycles = 0;
    always @(posedge clk) cycles <= cycles + 1;

    // ---------------- behavioural model state ----------------
    int     desc_m   [PD*PD];   // descriptor as the DUT should hold it
    int     new_desc [PD*PD];   // descriptor being sent
    int     cur_win  [PD][PD];  // window being sent
    int     m_idx;
    bit     m_first;
    longint m_best;
    int     m_best_idx;

    typedef struct {
        longint sc;
        int     idx;
        bit     last;
        longint bsc;
        int     bidx;
    } exp_t;
    exp_t exp_q[$];

    longint cap_score[$];
    int     cap_idx[$];
    int     best_pulses = 0;
    longint cap_bsc = 0;
    int     cap_bidx = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PD*PD; i++) desc_m[i] = 0;
        m_idx = 0; m_first = 1'b1; m_best = 0; m_best_idx = 0;
    endtask

    function automatic longint window_score();
        longint s = 0;
        for (int r = 0; r < PD; r++)
            for (int c = 0; c < PD; c++)
                s += longint'(desc_m[r*PD+c]) * longint'(cur_win[r][c]);
        return s;
    endfunction

    // Records what the completion of the current window must report.
    task automatic expect_window(input bit last);
        exp_t e;
        e.sc   = window_score();
        e.idx  = m_idx;
        e.last = last;
        if (m_first || e.sc > m_best) begin
            m_best = e.sc; m_best_idx = m_idx;
        end
        e.bsc  = m_best;
        e.bidx = m_best_idx;
        if (last) begin
            m_first = 1'b1; m_idx = 0;
        end else begin
            m_first = 1'b0;
            if (m_idx != 65535) m_idx++;
        end
        exp_q.push_back(e);
    endtask

    // Output monitor: every score pulse must match the model's next entry.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (score_valid) begin
                cap_score.push_back(longint'(score));
                cap_idx.push_back(int'(score_idx));
                if (best_valid) begin
                    best_pulses++;
                    cap_bsc  = longint'(best_score);
                    cap_bidx = int'(best_idx);
                end
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_score: got score %0d idx %0d, expected no pulse", score, score_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("score", score, e.sc);
                    chk("score_idx", score_idx, e.idx);
                    chk("best_score", best_score, e.bsc);
                    chk("best_idx", best_idx, e.bidx);
                    chk("best_valid", best_valid, e.last);
                end
            end else if (best_valid) begin
                n_tests++; n_fail++;
                $display("FAIL stray_best_valid: got 1, expected 0 without score_valid");
            end
        end
    end

    task automatic cyc();
        @(posedge clk); @(negedge clk);
    endtask

    // Offers one window row until accepted; starts and ends at a negedge.
    task automatic send_row(input int r, input bit last);
        logic [PD*PW-1:0] row;
        bit rdy;
        bit ok = 1'b0;
        for (int c = 0; c < PD; c++) row[c*PW +: PW] = PW'(cur_win[r][c]);
        win_row = row; win_last = last; win_valid = 1'b1;
        for (int t = 0; t < BUDGET; t++) begin
            #1; rdy = win_ready;
            cyc();
            if (rdy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL row_timeout: got no win_ready, expected accept of row %0d", r);
        end
        win_valid = 1'b0; win_last = 1'b0;
    endtask

    task automatic send_window(input bit last, input bit gaps);
        for (int r = 0; r < PD; r++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc();
            if (r == PD-1) expect_window(last);
            send_row(r, (r == PD-1) && last);
        end
    endtask

    // Sends descriptor beats b0..b1-1 of new_desc. stalls counts beats that
    // saw desc_ready low; blocked counts beats that saw win_ready high.
    task automatic load_desc(input int b0, input int b1, input bit chk_block,
                             output int stalls, output int blocked);
        logic [LN*PW-1:0] d;
        bit rdy;
        bit ok;
        stalls = 0; blocked = 0;
        for (int b = b0; b < b1; b++) begin
            for (int l = 0; l < LN; l++) d[l*PW +: PW] = PW'(new_desc[b*LN+l]);
            desc_data = d; desc_valid = 1'b1; ok = 1'b0;
            for (int t = 0; t < BUDGET; t++) begin
                #1; rdy = desc_ready;
                if (chk_block && win_ready) blocked++;
                if (!rdy) stalls++;
                cyc();
                if (rdy) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                n_tests++; n_fail++;
                $display("FAIL desc_timeout: got no desc_ready, expected accept of beat %0d", b);
            end
        end
        desc_valid = 1'b0;
        if (b1 == NB) for (int i = 0; i < PD*PD; i++) desc_m[i] = new_desc[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_desc_ready"},  desc_ready,  1);
        chk({tag, "_win_ready"},   win_ready,   0);
        chk({tag, "_desc_loaded"}, desc_loaded, 0);
        chk({tag, "_score_valid"}, score_valid, 0);
        chk({tag, "_score"},       score,       0);
        chk({tag, "_score_idx"},   score_idx,   0);
        chk({tag, "_best_valid"},  best_valid,  0);
        chk({tag, "_best_score"},  best_score,  0);
        chk({tag, "_best_idx"},    best_idx,    0);
    endtask

    task automatic fill_desc(input int v);
        for (int i = 0; i < PD*PD; i++) new_desc[i] = v;
    endtask

    task automatic fill_win_const(input int v);
        for (int r = 0; r < PD; r++) for (int c = 0; c < PD; c++) cur_win[r][c] = v;
    endtask

    task automatic fill_win_rand();
        for (int r = 0; r < PD; r++)
            for (int c = 0; c < PD; c++)
                cur_win[r][c] = ($urandom_range(0, 4) == 0) ? 255 : int'($urandom_range(0, 255));
    endtask

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int     dv;
        int     wv;
        longint exp_sc;
    } vec_t;

    initial begin
        vec_t   tbl[6];
        int     exp4[4];
        int     st, bl, st2, bl2, bp0, c0;
        bit     last;

        tbl[0] = '{1,   2,   512};
        tbl[1] = '{255, 255, 16646400};
        tbl[2] = '{3,   5,   3840};
        tbl[3] = '{0,   255, 0};
        tbl[4] = '{128, 2,   65536};
        tbl[5] = '{1,   1,   256};
        exp4   = '{100, 300, 300, 200};

        rst = 1'b0; clear = 1'b0; desc_valid = 1'b0; desc_data = '0;
        win_valid = 1'b0; win_row = '0; win_last = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        cyc();

        // ---- first load: desc_loaded rises right after the last beat ----
        fill_desc(1);
        load_desc(0, NB-1, 1'b0, st, bl);
        chk("loaded_early", desc_loaded, 0);
        load_desc(NB-1, NB, 1'b0, st2, bl);
        chk("desc_ready_held", st + st2, 0);
        chk("desc_loaded", desc_loaded, 1);

        // ---- table: uniform descriptor x uniform window ----
        for (int i = 0; i < 6; i++) begin
            fill_desc(tbl[i].dv);
            load_desc(0, NB, 1'b0, st, bl);
            fill_win_const(tbl[i].wv);
            cap_score.delete(); cap_idx.delete();
            bp0 = best_pulses;
            send_window(1'b1, 1'b0);
            cyc();
            chk("tbl_pulses", cap_score.size(), 1);
            if (cap_score.size() == 1) begin
                chk("tbl_score", cap_score[0], tbl[i].exp_sc);
                chk("tbl_idx", cap_idx[0], 0);
            end
            chk("tbl_best_pulse", best_pulses - bp0, 1);
            chk("tbl_best_score", cap_bsc, tbl[i].exp_sc);
            chk("tbl_best_idx", cap_bidx, 0);
        end

        // ---- four back-to-back windows, tie keeps the earlier index ----
        fill_desc(0); new_desc[0] = 1; new_desc[1] = 1;
        load_desc(0, NB, 1'b0, st, bl);
        cap_score.delete(); cap_idx.delete();
        bp0 = best_pulses;
        c0 = cycles;
        for (int w = 0; w < 4; w++) begin
            fill_win_rand();
            cur_win[0][0] = exp4[w] / 2; cur_win[0][1] = exp4[w] / 2;
            send_window(w == 3, 1'b0);
        end
        chk("b2b_cycles", cycles - c0, 4*PD);
        cyc();
        chk("b2b_pulses", cap_score.size(), 4);
        if (cap_score.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("b2b_score", cap_score[k], exp4[k]);
                chk("b2b_idx", cap_idx[k], k);
            end
        end
        chk("b2b_best_pulse", best_pulses - bp0, 1);
        chk("b2b_best_score", cap_bsc, 300);
        chk("b2b_best_idx", cap_bidx, 1);

        // ---- clear after 7 rows of a window ----
        cap_score.delete(); cap_idx.delete();
        fill_win_rand(); cur_win[0][0] = 200; cur_win[0][1] = 200;
        send_window(1'b0, 1'b0);                      // idx 0, score 400
        fill_win_rand();
        for (int r = 0; r < 7; r++) send_row(r, 1'b0);
        clear = 1'b1; win_valid = 1'b1; desc_valid = 1'b1;
        #1;
        chk("clear_win_ready", win_ready, 0);
        chk("clear_desc_ready", desc_ready, 0);
        cyc();
        clear = 1'b0; win_valid = 1'b0; desc_valid = 1'b0;
        m_first = 1'b1; m_idx = 0;
        fill_win_rand(); cur_win[0][0] = 10; cur_win[0][1] = 10;
        send_window(1'b1, 1'b0);                      // score 20 after clear
        cyc();
        chk("clear_pulses", cap_score.size(), 2);
        if (cap_score.size() == 2) begin
            chk("clear_score", cap_score[1], 20);
            chk("clear_idx", cap_idx[1], 0);
        end
        chk("clear_best_score", cap_bsc, 20);
        chk("clear_best_idx", cap_bidx, 0);
        chk("clear_desc_kept", desc_loaded, 1);

        // ---- reload while a window row is also offered ----
        for (int i = 0; i < PD*PD; i++) new_desc[i] = $urandom_range(0, 255);
        fill_win_rand();
        win_row = {4{$urandom}}; win_valid = 1'b1;
        load_desc(0, 1, 1'b1, st, bl);
        chk("reload_drop", desc_loaded, 0);
        load_desc(1, NB, 1'b1, st2, bl2);
        win_valid = 1'b0;
        chk("reload_win_blocked", bl + bl2, 0);
        chk("reload_loaded", desc_loaded, 1);
        send_window(1'b1, 1'b1);

        // ---- randomized windows against the model ----
        for (int it = 0; it < 8; it++) begin
            if (it % 3 == 0) begin
                for (int i = 0; i < PD*PD; i++) new_desc[i] = $urandom_range(0, 255);
                load_desc(0, NB, 1'b0, st, bl);
            end
            fill_win_rand();
            last = (it == 7) || ($urandom_range(0, 2) == 0);
            send_window(last, 1'b1);
        end
        cyc();
        chk("pending_before_reset", exp_q.size(), 0);

        // ---- reset mid-load ----
        for (int i = 0; i < PD*PD; i++) new_desc[i] = $urandom_range(0, 255);
        load_desc(0, 20, 1'b0, st, bl);
        #2; rst = 1'b0; #1;
        check_reset_outputs("rst_load");
        @(negedge clk); rst = 1'b1; model_reset();

        // ---- reset mid-window ----
        load_desc(0, NB, 1'b0, st, bl);
        fill_win_rand();
        for (int r = 0; r < 8; r++) send_row(r, 1'b0);
        #2; rst = 1'b0; #1;
        check_reset_outputs("rst_win");
        @(negedge clk); rst = 1'b1; model_reset();

        // ---- normal operation after reset ----
        cap_score.delete(); cap_idx.delete();
        for (int i = 0; i < PD*PD; i++) new_desc[i] = $urandom_range(0, 255);
        load_desc(0, NB, 1'b0, st, bl);
        fill_win_rand();
        send_window(1'b1, 1'b0);
        repeat (3) cyc();
        chk("post_reset_pulses", cap_score.size(), 1);
        chk("pending_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ncc_match_engine
`default_nettype wire
